// File: rtl/cn_msg_gen.sv
// Check-node message generator: takes one min/min2/min_idx/sign set and
// streams D offset-min-sum outgoing edge messages, one per accepted beat.
module cn_msg_gen #(
  parameter int                 data_w = 8,
  parameter int                 idx_w  = 8,
  parameter int                 D      = 5,
  parameter logic [data_w-1:0]  OFFSET = data_w'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [data_w-1:0] out_mag,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  localparam int KW = $clog2(D);
  localparam int CW = (idx_w > KW) ? idx_w : KW;
  localparam logic [KW-1:0] K_LAST = KW'(D - 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [KW-1:0]     k_reg;
  logic [data_w-1:0] min_reg, min2_reg;
  logic [idx_w-1:0]  min_idx_reg;
  logic [D-1:0]      sign_reg;
  logic              parity_reg;

  logic              emit, k_last, accept, beat_acc;
  logic [CW-1:0]     k_ext, idx_ext;
  logic [data_w-1:0] sel;

  assign k_last   = (k_reg == K_LAST);
  assign accept   = in_valid && in_ready;
  assign beat_acc = out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EMIT;
      EMIT: if (beat_acc && k_last && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs; a new set may be taken on the same edge the last beat leaves
  always_comb begin
    emit      = (state_reg == EMIT);
    out_valid = emit;
    in_ready  = !emit || (k_last && out_ready);
  end

  // Captured set and edge counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_reg       <= '0;
      min_reg     <= '0;
      min2_reg    <= '0;
      min_idx_reg <= '0;
      sign_reg    <= '0;
      parity_reg  <= 1'b0;
    end else if (accept) begin
      k_reg       <= '0;
      min_reg     <= min;
      min2_reg    <= min2;
      min_idx_reg <= min_idx;
      sign_reg    <= sign_in;
      parity_reg  <= ^sign_in;
    end else if (beat_acc && !k_last) begin
      k_reg <= k_reg + KW'(1);
    end
  end

  // Per-beat message; an out-of-range min_idx never matches k, so min is used throughout
  always_comb begin
    k_ext    = CW'(k_reg);
    idx_ext  = CW'(min_idx_reg);
    sel      = (k_ext == idx_ext) ? min2_reg : min_reg;
    out_mag  = '0;
    out_sign = 1'b0;
    out_idx  = '0;
    out_last = 1'b0;
    if (emit) begin
      out_mag  = (sel > OFFSET) ? (sel - OFFSET) : '0;
      out_sign = parity_reg ^ sign_reg[k_reg];
      out_idx  = idx_w'(k_reg);
      out_last = k_last;
    end
  end

endmodule

// File: tb/tb_cn_msg_gen.sv
// Bench for cn_msg_gen: queue-based model of expected beats checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_cn_msg_gen;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int D  = 5;
  localparam int OFF = 1;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] min, min2;
  logic [IW-1:0] min_idx;
  logic [D-1:0]  sign_in;
  logic          out_valid, out_ready;
  logic          out_sign;
  logic [DW-1:0] out_mag;
  logic [IW-1:0] out_idx;
  logic          out_last;

  cn_msg_gen #(.data_w(DW), .idx_w(IW), .D(D), .OFFSET(8'(OFF))) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .min(min), .min2(min2), .min_idx(min_idx), .sign_in(sign_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_mag(out_mag), .out_idx(out_idx), .out_last(out_last)
  );

  typedef struct packed {
    logic        s;
    logic [7:0]  m;
    logic [7:0]  i;
    logic        l;
    logic [31:0] c;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs[$];
  int tests = 0;
  int fails = 0;
  int cycle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of one set, straight from the offset-min-sum rules
  task automatic push_set(input int mn, input int mn2, input int idx, input logic [D-1:0] sg);
    beat_t b;
    int sel;
    for (int k = 0; k < D; k++) begin
      sel = (idx == k) ? mn2 : mn;
      b.s = (^sg) ^ sg[k];
      b.m = 8'((sel > OFF) ? sel - OFF : 0);
      b.i = 8'(k);
      b.l = (k == D - 1);
      b.c = 0;
      exp_q.push_back(b);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    beat_t e, o;
    logic model_ready;
    if (rst) begin
      exp_q.delete();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_mag", 32'(out_mag), 0);
    end else begin
      model_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(model_ready));
      if (out_valid && exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_sign", 32'(out_sign), 32'(e.s));
        check("out_mag", 32'(out_mag), 32'(e.m));
        check("out_idx", 32'(out_idx), 32'(e.i));
        check("out_last", 32'(out_last), 32'(e.l));
        if (out_ready) begin
          o.s = out_sign; o.m = out_mag; o.i = out_idx; o.l = out_last; o.c = 32'(cycle);
          obs.push_back(o);
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && model_ready)
        push_set(int'(min), int'(min2), int'(min_idx), sign_in);
    end
  end

  task automatic send(input int mn, input int mn2, input int idx, input logic [D-1:0] sg);
    @(posedge clk); #1;
    in_valid = 1'b1; min = 8'(mn); min2 = 8'(mn2); min_idx = 8'(idx); sign_in = sg;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    logic [7:0] sig_exp [5];
    logic [7:0] mag_exp [5];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    min = '0; min2 = '0; min_idx = '0; sign_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 0);
    check("reset_in_ready", 32'(in_ready), 1);
    check("reset_out_sign", 32'(out_sign), 0);
    check("reset_out_idx", 32'(out_idx), 0);
    check("reset_out_last", 32'(out_last), 0);

    // Basic set
    s = obs.size();
    send(3, 7, 2, 5'b00101);
    check("basic_k0_in_ready", 32'(in_ready), 0);
    wait_cycles(6);
    sig_exp = '{8'd1, 8'd0, 8'd1, 8'd0, 8'd0};
    mag_exp = '{8'd2, 8'd2, 8'd6, 8'd2, 8'd2};
    check("basic_beats", 32'(obs.size() - s), 5);
    for (int i = 0; i < 5; i++) begin
      if (obs.size() > s + i) begin
        check("basic_sign", 32'(obs[s+i].s), 32'(sig_exp[i]));
        check("basic_mag", 32'(obs[s+i].m), 32'(mag_exp[i]));
        check("basic_last", 32'(obs[s+i].l), 32'(i == 4));
      end
    end

    // Saturation
    s = obs.size();
    send(0, 1, 4, 5'b00000);
    wait_cycles(6);
    check("sat_beats", 32'(obs.size() - s), 5);
    for (int i = 0; i < 5; i++)
      if (obs.size() > s + i) begin
        check("sat_mag", 32'(obs[s+i].m), 0);
        check("sat_sign", 32'(obs[s+i].s), 0);
      end

    // Backpressure at k=1
    s = obs.size();
    send(4, 9, 3, 5'b10011);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_idx", 32'(out_idx), 1);
      check("bp_hold_mag", 32'(out_mag), 3);
      check("bp_hold_valid", 32'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_cycles(5);
    check("bp_beats", 32'(obs.size() - s), 5);
    for (int i = 0; i < 5; i++)
      if (obs.size() > s + i) check("bp_order", 32'(obs[s+i].i), 32'(i));

    // Back-to-back sets
    s = obs.size();
    send(5, 6, 0, 5'b01000);
    repeat (4) @(posedge clk);
    #1;
    check("b2b_k4_idx", 32'(out_idx), 4);
    in_valid = 1'b1; min = 8'd2; min2 = 8'd8; min_idx = 8'd1; sign_in = 5'b00001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_next_valid", 32'(out_valid), 1);
    check("b2b_next_idx", 32'(out_idx), 0);
    check("b2b_next_mag", 32'(out_mag), 1);
    wait_cycles(6);
    check("b2b_beats", 32'(obs.size() - s), 10);
    if (obs.size() >= s + 6)
      check("b2b_no_gap", obs[s+5].c - obs[s+4].c, 1);

    // min_idx out of range
    s = obs.size();
    send(4, 9, 5, 5'b11010);
    wait_cycles(6);
    check("oor_beats", 32'(obs.size() - s), 5);
    for (int i = 0; i < 5; i++)
      if (obs.size() > s + i) check("oor_mag", 32'(obs[s+i].m), 3);

    // Reset mid-set at k=2
    s = obs.size();
    send(6, 10, 0, 5'b00111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_idx", 32'(out_idx), 2);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_rel_in_ready", 32'(in_ready), 1);
    check("rst_rel_valid", 32'(out_valid), 0);
    wait_cycles(2);
    check("rst_abandoned", 32'(obs.size() - s), 2);

    // Fresh set after reset starts at k=0
    s = obs.size();
    send(3, 7, 2, 5'b00101);
    check("post_rst_idx", 32'(out_idx), 0);
    check("post_rst_mag", 32'(out_mag), 2);
    wait_cycles(6);
    check("post_rst_beats", 32'(obs.size() - s), 5);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cn_msg_gen.md
CN_MSG_GEN -- requirements
Module: cn_msg_gen

Interface
REQ-001 SHALL have parameter data_w, default 8, magnitude width of min/min2 and output magnitude.
REQ-002 SHALL have parameter idx_w, default 8, width of min_idx and edge index.
REQ-003 SHALL have parameter D, default 5, check-node degree (edges per message set), D >= 2.
REQ-004 SHALL have parameter OFFSET, default 1, offset-min-sum subtrahend, width data_w.
REQ-005 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have in_valid  input  1  min/min2/min_idx/sign_in set valid.
REQ-008 SHALL have in_ready  output  1  block can accept a set this cycle.
REQ-009 SHALL have min  input  data_w  smallest input magnitude.
REQ-010 SHALL have min2  input  data_w  second-smallest input magnitude.
REQ-011 SHALL have min_idx  input  idx_w  edge index of min.
REQ-012 SHALL have sign_in  input  D  sign bit of each incoming edge message; bit k = edge k.
REQ-013 SHALL have out_valid  output  1  out_sign/out_mag/out_idx valid.
REQ-014 SHALL have out_ready  input  1  downstream accepts current beat.
REQ-015 SHALL have out_sign  output  1  sign of outgoing message.
REQ-016 SHALL have out_mag  output  data_w  magnitude of outgoing message.
REQ-017 SHALL have out_idx  output  idx_w  edge index k of current beat.
REQ-018 SHALL have out_last  output  1  high on beat with out_idx == D-1.

Function
REQ-019 SHALL implement FSM states IDLE and EMIT, plus edge counter k (0..D-1) and registers for min, min2, min_idx, sign_in, parity.
REQ-020 SHALL accept a set when in_valid && in_ready at a rising edge: capture inputs, parity = XOR of all sign_in bits, k <= 0, state <= EMIT.
REQ-021 SHALL drive in_ready = (state == IDLE) || (state == EMIT && k == D-1 && out_ready).
REQ-022 SHALL drive out_valid = (state == EMIT); first beat appears the cycle after acceptance (latency 1).
REQ-023 SHALL compute per-beat sel = (k == captured min_idx) ? min2 : min; out_mag = sel - OFFSET when sel > OFFSET, else 0 (saturating, no wrap).
REQ-024 SHALL compute out_sign = parity XOR captured sign_in[k].
REQ-025 SHALL drive out_idx = k and out_last = (k == D-1).
REQ-026 SHALL, when captured min_idx >= D, use min for every edge.
REQ-027 SHALL advance k by 1 on each beat with out_valid && out_ready and k < D-1; SHALL hold k and all outputs stable while out_valid && !out_ready.
REQ-028 SHALL, on accepted last beat (k == D-1) with no simultaneous accepted set, go to IDLE.
REQ-029 SHALL, on accepted last beat with simultaneous accepted set, capture the new set, reset k to 0 and stay in EMIT, no bubble cycle.
REQ-030 SHALL ignore in_valid whenever in_ready is low; captured set not altered.
REQ-031 SHALL emit exactly D beats per accepted set, in order k = 0..D-1.

Reset
REQ-032 SHALL on rst: state = IDLE, k = 0, captured registers = 0; out_valid = 0, out_sign = 0, out_mag = 0, out_idx = 0, out_last = 0, in_ready = 1 after release.
REQ-033 SHALL abandon any in-progress set on rst asserted mid-EMIT; no further beats of that set emitted.

Verification (D=5, data_w=8, OFFSET=1)
REQ-034 SHALL test basic set: min=3, min2=7, min_idx=2, sign_in=5'b00101, out_ready=1 -> beats k0..k4 (sign,mag) = (1,2),(0,2),(1,6),(0,2),(0,2); out_last only on k4; in_ready low during k0..k3.
REQ-035 SHALL test saturation: min=0, min2=1, min_idx=4, sign_in=0 -> all out_mag = 0, signs 0.
REQ-036 SHALL test backpressure: out_ready low for 3 cycles at k=1 -> out_idx=1 and data held stable, then k2..k4 continue; 5 beats total.
REQ-037 SHALL test back-to-back: second set valid while k=4 accepted -> first beat of set 2 in next cycle, no idle gap.
REQ-038 SHALL test min_idx=5 (out of range), min=4, min2=9 -> all five beats out_mag = 3.
REQ-039 SHALL test rst pulse at k=2 -> out_valid = 0 immediately, in_ready = 1 after release, next set starts at k=0.
